// File: rtl/tt_stim_pkg.sv
// Shared definitions for the Tiny Tapeout stimulus controller.
// Covers the host opcodes, the error byte, the FSM state encoding and the counter widths.
package tt_stim_pkg;

    localparam logic [7:0] OP_SET_UI      = 8'h01;
    localparam logic [7:0] OP_SET_UIO_OUT = 8'h02;
    localparam logic [7:0] OP_SET_UIO_OE  = 8'h03;
    localparam logic [7:0] OP_RST_ASSERT  = 8'h04;
    localparam logic [7:0] OP_RST_RELEASE = 8'h05;
    localparam logic [7:0] OP_STEP        = 8'h06;
    localparam logic [7:0] OP_READ_UO     = 8'h07;
    localparam logic [7:0] OP_READ_UIO    = 8'h08;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam int HALF_W = 8;
    localparam int STEP_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARG     = 3'd1,
        ST_STEP_HI = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    function automatic logic needs_arg(input logic [7:0] op);
        return op inside {OP_SET_UI, OP_SET_UIO_OUT, OP_SET_UIO_OE, OP_STEP};
    endfunction

    // A requested count of zero stands for the full 256 pulses.
    function automatic logic [STEP_W-1:0] step_count(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/tt_stim_clkgen.sv
// Half-period and pulse counters for stepping the design clock.
// It flags each finished half period and the end of the last low phase.
module tt_stim_clkgen
    import tt_stim_pkg::*;
#(
    parameter int HALF_PER = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] load_count,
    input  logic              run,
    input  logic              low_phase,
    output logic              half_done,
    output logic              done
);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PER - 1);

    logic [HALF_W-1:0] half_cnt;
    logic [STEP_W-1:0] step_cnt;

    assign half_done = run && (half_cnt == HALF_LAST);
    assign done      = half_done && low_phase && (step_cnt == 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt <= '0;
            step_cnt <= '0;
        end else if (load) begin
            half_cnt <= '0;
            step_cnt <= load_count;
        end else if (run) begin
            if (half_done) begin
                half_cnt <= '0;
                // A pulse is complete once its low half has elapsed.
                if (low_phase) begin
                    step_cnt <= step_cnt - 9'd1;
                end
            end else begin
                half_cnt <= half_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/tt_stim_ctrl.sv
// Host-command controller that drives a Tiny Tapeout design's pins, reset and stepped clock.
// Every byte-level output to the design and the host comes straight from a flop.
module tt_stim_ctrl
    import tt_stim_pkg::*;
#(
    parameter int HALF_PER = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] dut_ui_in,
    input  logic [7:0] dut_uo_out,
    input  logic [7:0] dut_uio_in,
    output logic [7:0] dut_uio_out,
    output logic [7:0] dut_uio_oe,
    output logic       dut_clk,
    output logic       dut_rst_n,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Both links transfer one byte on any clk edge where valid and ready are high together.
    // A source holds valid and data steady until that edge, and ready may be
    // asserted with no valid present without side effect.
    state_t     state, state_nx;
    logic [7:0] op_q;
    logic       cmd_fire, rsp_fire;
    logic       step_load, half_done, step_done;
    logic       step_run, step_low;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign step_run  = (state == ST_STEP_HI) || (state == ST_STEP_LO);
    assign step_low  = (state == ST_STEP_LO);

    tt_stim_clkgen #(
        .HALF_PER(HALF_PER)
    ) u_clkgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (step_load),
        .load_count (step_count(cmd_data)),
        .run        (step_run),
        .low_phase  (step_low),
        .half_done  (half_done),
        .done       (step_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        step_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (needs_arg(cmd_data)) begin
                        state_nx = ST_ARG;
                    end else if (cmd_data == OP_RST_ASSERT || cmd_data == OP_RST_RELEASE) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_RESP;
                    end
                end
            end
            ST_ARG: begin
                if (cmd_fire) begin
                    if (op_q == OP_STEP) begin
                        state_nx  = ST_STEP_HI;
                        step_load = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_STEP_HI: begin
                if (half_done) state_nx = ST_STEP_LO;
            end
            ST_STEP_LO: begin
                if (step_done) begin
                    state_nx = ST_IDLE;
                end else if (half_done) begin
                    state_nx = ST_STEP_HI;
                end
            end
            ST_RESP: begin
                if (rsp_fire) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            op_q        <= 8'h00;
            dut_clk     <= 1'b0;
            dut_rst_n   <= 1'b0;
            dut_ui_in   <= 8'h00;
            dut_uio_out <= 8'h00;
            dut_uio_oe  <= 8'h00;
        end else begin
            cmd_ready <= (state_nx == ST_IDLE) || (state_nx == ST_ARG);
            rsp_valid <= (state_nx == ST_RESP);
            dut_clk   <= (state_nx == ST_STEP_HI);

            if (state == ST_IDLE && cmd_fire) begin
                op_q <= cmd_data;
                case (cmd_data)
                    OP_RST_ASSERT:  dut_rst_n <= 1'b0;
                    OP_RST_RELEASE: dut_rst_n <= 1'b1;
                    OP_READ_UO:     rsp_data  <= dut_uo_out;
                    OP_READ_UIO:    rsp_data  <= dut_uio_in;
                    OP_SET_UI, OP_SET_UIO_OUT, OP_SET_UIO_OE, OP_STEP: ;
                    default:        rsp_data  <= ERR_BYTE;
                endcase
            end

            if (state == ST_ARG && cmd_fire) begin
                case (op_q)
                    OP_SET_UI:      dut_ui_in   <= cmd_data;
                    OP_SET_UIO_OUT: dut_uio_out <= cmd_data;
                    OP_SET_UIO_OE:  dut_uio_oe  <= cmd_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_stim_ctrl.sv
// Self-checking bench for tt_stim_ctrl: command table, response scoreboard,
// clock stepping and asynchronous reset corner cases.
module tb_tt_stim_ctrl;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] dut_ui_in;
    logic [7:0] dut_uo_out;
    logic [7:0] dut_uio_in;
    logic [7:0] dut_uio_out;
    logic [7:0] dut_uio_oe;
    logic       dut_clk;
    logic       dut_rst_n;
    logic       busy;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    tt_stim_ctrl #(
        .HALF_PER(H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .dut_ui_in   (dut_ui_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_in  (dut_uio_in),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe),
        .dut_clk     (dut_clk),
        .dut_rst_n   (dut_rst_n),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [7:0] op;
        logic       has_arg;
        logic [7:0] arg;
        logic [7:0] uo;
        logic [7:0] uio;
        logic       has_rsp;
        logic [7:0] rsp;
        int         hold;
        logic [7:0] ui;
        logic [7:0] uio_out;
        logic [7:0] uio_oe;
        logic       rst_o;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dut_clk"},   32'(dut_clk),     0);
        check({tag, "_dut_rst_n"}, 32'(dut_rst_n),   0);
        check({tag, "_ui"},        32'(dut_ui_in),   0);
        check({tag, "_uio_out"},   32'(dut_uio_out), 0);
        check({tag, "_uio_oe"},    32'(dut_uio_oe),  0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid),   0);
        check({tag, "_rsp_data"},  32'(rsp_data),    0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready),   0);
        check({tag, "_busy"},      32'(busy),        0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold);
        logic [7:0] first;
        logic [7:0] want;
        int unstable = 0;
        @(negedge clk);
        check("rsp_valid_rise", 32'(rsp_valid), 1);
        first = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== first) unstable++;
        end
        check("rsp_hold", 32'(unstable), 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (exp_q.size() == 0) begin
            check("rsp_q_empty", 32'(exp_q.size()), 1);
        end else begin
            want = exp_q.pop_front();
            check("rsp_data", 32'(first), 32'(want));
        end
        @(negedge clk);
        check("rsp_valid_fall", 32'(rsp_valid), 0);
    endtask

    task automatic run_step(input logic [7:0] n, input int pulses);
        int   cycles = 0;
        int   edges = 0;
        int   pat_err = 0;
        int   rdy_err = 0;
        logic prev = 1'b0;
        logic exp_clk;
        send_byte(8'h06);
        send_byte(n);
        while (cycles < 4000) begin
            @(negedge clk);
            if (!busy) break;
            exp_clk = ((cycles / H) % 2) == 0;
            if (dut_clk !== exp_clk) pat_err++;
            if (cmd_ready !== 1'b0) rdy_err++;
            if (dut_clk && !prev) edges++;
            prev = dut_clk;
            cycles++;
        end
        check($sformatf("step%0d_edges", pulses),   32'(edges),   32'(pulses));
        check($sformatf("step%0d_cycles", pulses),  32'(cycles),  32'(pulses * 2 * H));
        check($sformatf("step%0d_pattern", pulses), 32'(pat_err), 0);
        check($sformatf("step%0d_ready", pulses),   32'(rdy_err), 0);
        check($sformatf("step%0d_clk_after", pulses), 32'(dut_clk), 0);
    endtask

    initial begin
        logic [7:0] r;
        logic       use_uio;
        int         w;

        cmd_data   = 8'h00;
        cmd_valid  = 1'b0;
        rsp_ready  = 1'b0;
        dut_uo_out = 8'h00;
        dut_uio_in = 8'h00;
        rst_n      = 1'b0;

        //          op     arg?  arg    uo     uio    rsp?  rsp    hold ui     uio_o  uio_oe rst
        vecs[0]  = '{8'h01, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'hA5, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'h02, 1'b1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'hA5, 8'h5A, 8'h00, 1'b0};
        vecs[2]  = '{8'h03, 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'hA5, 8'h5A, 8'hF0, 1'b0};
        vecs[3]  = '{8'h05, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'hA5, 8'h5A, 8'hF0, 1'b1};
        vecs[4]  = '{8'h07, 1'b0, 8'h00, 8'h3C, 8'h81, 1'b1, 8'h3C, 10, 8'hA5, 8'h5A, 8'hF0, 1'b1};
        vecs[5]  = '{8'h55, 1'b0, 8'h00, 8'h11, 8'h22, 1'b1, 8'hEE, 2,  8'hA5, 8'h5A, 8'hF0, 1'b1};
        vecs[6]  = '{8'h08, 1'b0, 8'h00, 8'h66, 8'hC3, 1'b1, 8'hC3, 0,  8'hA5, 8'h5A, 8'hF0, 1'b1};
        vecs[7]  = '{8'h04, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'hA5, 8'h5A, 8'hF0, 1'b0};
        vecs[8]  = '{8'h01, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'h00, 8'h5A, 8'hF0, 1'b0};
        vecs[9]  = '{8'hFF, 1'b0, 8'h00, 8'h12, 8'h34, 1'b1, 8'hEE, 1,  8'h00, 8'h5A, 8'hF0, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 8'h00, 8'h56, 8'h78, 1'b1, 8'hEE, 3,  8'h00, 8'h5A, 8'hF0, 1'b0};
        vecs[11] = '{8'h05, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 0,  8'h00, 8'h5A, 8'hF0, 1'b1};

        // reset state and first-edge readiness
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(cmd_ready), 0);
        @(negedge clk);
        check("ready_after_edge", 32'(cmd_ready), 1);

        // table-driven commands
        for (int i = 0; i < 12; i++) begin
            dut_uo_out = vecs[i].uo;
            dut_uio_in = vecs[i].uio;
            if (vecs[i].has_rsp) exp_q.push_back(vecs[i].rsp);
            send_byte(vecs[i].op);
            if (vecs[i].has_arg) send_byte(vecs[i].arg);
            // inputs moving after capture must not disturb the response
            dut_uo_out = ~vecs[i].uo;
            dut_uio_in = ~vecs[i].uio;
            if (vecs[i].has_rsp) begin
                get_rsp(vecs[i].hold);
            end else begin
                @(negedge clk);
                check($sformatf("rsp_valid_none[%0d]", i), 32'(rsp_valid), 0);
            end
            check($sformatf("ui[%0d]", i),      32'(dut_ui_in),   32'(vecs[i].ui));
            check($sformatf("uio_out[%0d]", i), 32'(dut_uio_out), 32'(vecs[i].uio_out));
            check($sformatf("uio_oe[%0d]", i),  32'(dut_uio_oe),  32'(vecs[i].uio_oe));
            check($sformatf("rst_o[%0d]", i),   32'(dut_rst_n),   32'(vecs[i].rst_o));
            check($sformatf("busy[%0d]", i),    32'(busy),        0);
        end

        // random reads through the scoreboard
        for (int i = 0; i < 6; i++) begin
            r       = 8'($urandom_range(0, 255));
            use_uio = 1'($urandom_range(0, 1));
            dut_uo_out = use_uio ? ~r : r;
            dut_uio_in = use_uio ? r : ~r;
            exp_q.push_back(r);
            send_byte(use_uio ? 8'h08 : 8'h07);
            get_rsp($urandom_range(0, 4));
        end

        // rsp_ready with nothing pending
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ready_valid", 32'(rsp_valid), 0);
            check("idle_ready_busy", 32'(busy), 0);
        end
        rsp_ready = 1'b0;

        // clock stepping
        run_step(8'h03, 3);
        run_step(8'h01, 1);
        run_step(8'h00, 256);

        // asynchronous reset in the high phase of a step
        send_byte(8'h01);
        send_byte(8'h77);
        @(negedge clk);
        check("ui_pre_reset", 32'(dut_ui_in), 32'h77);
        send_byte(8'h06);
        send_byte(8'h05);
        w = 0;
        while (!dut_clk && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("step_hi_reached", 32'(dut_clk), 1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_step");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("clk_held_in_reset", 32'(dut_clk), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("clk_after_abort", 32'(dut_clk), 0);
        end
        check("busy_after_abort", 32'(busy), 0);

        // asynchronous reset while a response is pending
        dut_uo_out = 8'h99;
        send_byte(8'h07);
        @(negedge clk);
        check("resp_pending", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_resp_valid", 32'(rsp_valid), 0);
        check("rst_resp_data", 32'(rsp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dut_uo_out = 8'h42;
        exp_q.push_back(8'h42);
        send_byte(8'h07);
        get_rsp(1);

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_stim_ctrl.md
TT_STIM_CTRL -- requirements
Module: tt_stim_ctrl

Interface
REQ-001 Parameter HALF_PER, default 4: dut_clk half-period in clk cycles, legal range 1..255.
REQ-002 clk  in  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_data  in  8  command or argument byte from the host link.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a byte transfers on a cycle where both are high.
REQ-006 rsp_data  out  8  response byte to the host link.
REQ-007 rsp_valid / rsp_ready  out / in  1 / 1  response handshake; a byte transfers on a cycle where both are high.
REQ-008 dut_ui_in  out  8  drives the design's dedicated inputs.
REQ-009 dut_uo_out  in  8  design's dedicated outputs.
REQ-010 dut_uio_in  in  8  design's bidirectional pin readback.
REQ-011 dut_uio_out / dut_uio_oe  out / out  8 / 8  bidirectional drive value and output enable.
REQ-012 dut_clk / dut_rst_n  out / out  1 / 1  generated design clock and design reset.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 Opcode map:
- 0x01 SET_UI + 1 argument byte.
- 0x02 SET_UIO_OUT + 1 argument byte.
- 0x03 SET_UIO_OE + 1 argument byte.
- 0x04 RST_ASSERT: dut_rst_n=0.
- 0x05 RST_RELEASE: dut_rst_n=1.
- 0x06 STEP + count byte N.
- 0x07 READ_UO.
- 0x08 READ_UIO.
REQ-015 FSM states IDLE, ARG, STEP_HI, STEP_LO, RESP; cmd_ready=1 only in IDLE and ARG.
REQ-016 IDLE, on accepting an opcode:
- 0x01/0x02/0x03/0x06 -> ARG.
- 0x04/0x05 -> apply on the next cycle, stay in IDLE.
- 0x07/0x08 -> RESP.
- Any other value -> RESP with rsp_data=0xEE.
REQ-017 ARG, on accepting the argument: SET_* updates the target register one cycle after acceptance, then -> IDLE; STEP loads count (N=0 means 256) -> STEP_HI.
REQ-018 READ_UO / READ_UIO capture dut_uo_out / dut_uio_in into rsp_data on the cycle the opcode is accepted; rsp_valid rises the next cycle.
REQ-019 RESP: rsp_valid=1 and rsp_data held stable until rsp_ready=1; the handshake cycle -> IDLE, with rsp_valid=0 the following cycle.
REQ-020 STEP_HI: dut_clk=1 for exactly HALF_PER clk cycles -> STEP_LO.
REQ-021 STEP_LO: dut_clk=0 for exactly HALF_PER cycles; then decrement count; count reaching 0 -> IDLE, else -> STEP_HI.
REQ-022 A STEP of N produces exactly N rising edges on dut_clk; dut_clk=0 outside STEP_HI.
REQ-023 dut_clk, dut_rst_n and all dut_* outputs are driven directly from flops (glitch-free).
REQ-024 cmd_valid while cmd_ready=0 is not consumed; the byte waits and is accepted later.
REQ-025 The half-period counter is 8 bits and the step counter is 9 bits; a loaded count of 256 performs 256 pulses.
REQ-026 rsp_ready asserted while no response is pending has no effect.

Reset
REQ-027 rst_n low asynchronously forces:
- state=IDLE; count and half-period counter = 0.
- dut_clk=0, dut_rst_n=0.
- dut_ui_in=0x00, dut_uio_out=0x00, dut_uio_oe=0x00.
- rsp_valid=0, rsp_data=0x00, cmd_ready=0, busy=0.
REQ-028 Reset mid-STEP or mid-RESP aborts the operation with no further dut_clk edge; the pending response is discarded.
REQ-029 Reset deassertion takes effect synchronously to clk; cmd_ready=1 from the first clk edge after deassertion.

Structure
REQ-030 Package tt_stim_pkg holds the opcode constants, the error byte 0xEE and the FSM state enum.
REQ-031 One sub-module, tt_stim_clkgen, holds the half-period counter and the step counter and issues a done pulse; the FSM and registers stay in tt_stim_ctrl.

Verification
REQ-032 Bench covers at least these directed scenarios:
- Reset, then send 0x01,0xA5 -> dut_ui_in=0xA5 one cycle after the argument handshake; no rsp_valid.
- HALF_PER=4, send 0x06,0x03 -> exactly 3 dut_clk rising edges, each high 4 cycles and low 4 cycles, busy high throughout, cmd_ready=0 throughout.
- Send 0x06,0x00 -> 256 pulses; busy falls after the 2048th cycle of stepping.
- dut_uo_out=0x3C, send 0x07 with rsp_ready=0 for 10 cycles -> rsp_valid=1, rsp_data=0x3C held stable; one handshake; then rsp_valid=0.
- Send opcode 0x55 -> response 0xEE; the next 0x08 returns dut_uio_in correctly.
- Assert rst_n during STEP_HI -> dut_clk=0 and dut_rst_n=0 immediately (asynchronously); all outputs at reset values.
